// File: rtl/icache_prefetch_queue.sv
// Prefetch request queue between the icache prefetch engine and the memory-request arbiter.
// Drops requests whose line address is already queued or recently issued; keeps saturating drop/issue counts.
module icache_prefetch_queue #(
    parameter int QDEPTH                  = 4,
    parameter int HIST_DEPTH              = 4,
    parameter int CNT_WIDTH               = 16,
    parameter int ICACHE_REQ_OPCODE_WIDTH = 4,
    parameter int REQ_ADDR_WIDTH          = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_req_vld,
    output logic                               in_req_rdy,
    input  logic [ICACHE_REQ_OPCODE_WIDTH-1:0] in_req_opcode,
    input  logic [REQ_ADDR_WIDTH-1:0]          in_req_addr,
    output logic                               out_req_vld,
    input  logic                               out_req_rdy,
    output logic [ICACHE_REQ_OPCODE_WIDTH-1:0] out_req_opcode,
    output logic [REQ_ADDR_WIDTH-1:0]          out_req_addr,
    output logic [CNT_WIDTH-1:0]               drop_cnt,
    output logic [CNT_WIDTH-1:0]               issue_cnt
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]     PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]     OCC_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     OCC_FULL   = CNT_W'(QDEPTH);
    localparam logic [CNT_WIDTH-1:0] STAT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] STAT_MAX   = {CNT_WIDTH{1'b1}};

    logic [ICACHE_REQ_OPCODE_WIDTH-1:0] mem_opcode_r [QDEPTH];
    logic [REQ_ADDR_WIDTH-1:0]          mem_addr_r   [QDEPTH];
    logic [QDEPTH-1:0]                  entry_vld_r;
    logic [REQ_ADDR_WIDTH-1:0]          hist_addr_r  [HIST_DEPTH];
    logic [HIST_DEPTH-1:0]              hist_vld_r;
    logic [PTR_W-1:0]                   rd_ptr_r;
    logic [PTR_W-1:0]                   wr_ptr_r;
    logic [CNT_W-1:0]                   count_r;

    logic                               dup_s;
    logic                               accept_s;
    logic                               enq_s;
    logic                               drop_s;
    logic                               deq_s;
    logic [PTR_W-1:0]                   rd_ptr_nxt_s;
    logic [PTR_W-1:0]                   wr_ptr_nxt_s;
    logic [CNT_W-1:0]                   count_nxt_s;
    logic [REQ_ADDR_WIDTH-1:0]          head_addr_s;
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0] head_opcode_s;

    // Duplicate detection against queued entries and issue history, on pre-update state.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            dup_s = dup_s | (entry_vld_r[i] && (mem_addr_r[i] == in_req_addr));
        end
        for (int j = 0; j < HIST_DEPTH; j++) begin
            dup_s = dup_s | (hist_vld_r[j] && (hist_addr_r[j] == in_req_addr));
        end
    end

    assign accept_s = in_req_vld && in_req_rdy;
    assign enq_s    = accept_s && !dup_s && !flush;
    assign drop_s   = accept_s && dup_s && !flush;
    assign deq_s    = out_req_vld && out_req_rdy && !flush;

    // Next pointer/occupancy state and the entry that becomes the head after this edge.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            rd_ptr_nxt_s = '0;
            wr_ptr_nxt_s = '0;
            count_nxt_s  = '0;
        end else begin
            rd_ptr_nxt_s = deq_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            wr_ptr_nxt_s = enq_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            case ({enq_s, deq_s})
                2'b10:   count_nxt_s = count_r + OCC_ONE;
                2'b01:   count_nxt_s = count_r - OCC_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
        // The new head is the incoming request only when it lands in the head slot.
        if (enq_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_addr_s   = in_req_addr;
            head_opcode_s = in_req_opcode;
        end else begin
            head_addr_s   = mem_addr_r[rd_ptr_nxt_s];
            head_opcode_s = mem_opcode_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage; contents are qualified by entry_vld_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_addr_r[wr_ptr_r]   <= in_req_addr;
            mem_opcode_r[wr_ptr_r] <= in_req_opcode;
        end
    end

    // Occupancy, entry valids, issue history and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            entry_vld_r <= '0;
            hist_vld_r  <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_addr_r[k] <= '0;
            end
            drop_cnt    <= '0;
            issue_cnt   <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            if (flush) begin
                entry_vld_r <= '0;
                hist_vld_r  <= '0;
            end else begin
                if (enq_s) begin
                    entry_vld_r[wr_ptr_r] <= 1'b1;
                end
                if (deq_s) begin
                    entry_vld_r[rd_ptr_r] <= 1'b0;
                    for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                        hist_addr_r[k] <= hist_addr_r[k-1];
                        hist_vld_r[k]  <= hist_vld_r[k-1];
                    end
                    hist_addr_r[0] <= out_req_addr;
                    hist_vld_r[0]  <= 1'b1;
                end
            end
            if (drop_s && (drop_cnt != STAT_MAX)) begin
                drop_cnt <= drop_cnt + STAT_ONE;
            end
            if (deq_s && (issue_cnt != STAT_MAX)) begin
                issue_cnt <= issue_cnt + STAT_ONE;
            end
        end
    end

    // Registered handshake and head outputs; head data holds while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_req_rdy     <= 1'b1;
            out_req_vld    <= 1'b0;
            out_req_addr   <= '0;
            out_req_opcode <= '0;
        end else begin
            in_req_rdy  <= (count_nxt_s != OCC_FULL);
            out_req_vld <= (count_nxt_s != '0);
            if (count_nxt_s != '0) begin
                out_req_addr   <= head_addr_s;
                out_req_opcode <= head_opcode_s;
            end
        end
    end

endmodule

// File: tb/tb_icache_prefetch_queue.sv
// Directed, table-driven bench for icache_prefetch_queue (QDEPTH=4, HIST_DEPTH=4).
module tb_icache_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_req_vld = 1'b0;
    logic        in_req_rdy;
    logic [3:0]  in_req_opcode = 4'h0;
    logic [31:0] in_req_addr = 32'h0;
    logic        out_req_vld;
    logic        out_req_rdy = 1'b0;
    logic [3:0]  out_req_opcode;
    logic [31:0] out_req_addr;
    logic [15:0] drop_cnt;
    logic [15:0] issue_cnt;

    int checks = 0;
    int failures = 0;

    icache_prefetch_queue #(
        .QDEPTH(4), .HIST_DEPTH(4), .CNT_WIDTH(16),
        .ICACHE_REQ_OPCODE_WIDTH(4), .REQ_ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy),
        .in_req_opcode(in_req_opcode), .in_req_addr(in_req_addr),
        .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy),
        .out_req_opcode(out_req_opcode), .out_req_addr(out_req_addr),
        .drop_cnt(drop_cnt), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic        rdy;
        logic        fl;
        logic        e_in_rdy;
        logic        e_out_vld;
        logic [31:0] e_addr;
        int          e_drop;
        int          e_issue;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] op_of(input logic [31:0] a);
        return a[3:0] ^ 4'hA;
    endfunction

    task automatic push(input logic vld, input logic [31:0] addr, input logic rdy, input logic fl,
                        input logic e_in_rdy, input logic e_out_vld, input logic [31:0] e_addr,
                        input int e_drop, input int e_issue);
        vec_t v;
        v.vld = vld; v.addr = addr; v.rdy = rdy; v.fl = fl;
        v.e_in_rdy = e_in_rdy; v.e_out_vld = e_out_vld; v.e_addr = e_addr;
        v.e_drop = e_drop; v.e_issue = e_issue;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input int idx, input logic e_in_rdy, input logic e_out_vld,
                                 input logic [31:0] e_addr, input logic [3:0] e_op,
                                 input int e_drop, input int e_issue);
        chk($sformatf("v%0d in_req_rdy", idx), {31'h0, in_req_rdy}, {31'h0, e_in_rdy});
        chk($sformatf("v%0d out_req_vld", idx), {31'h0, out_req_vld}, {31'h0, e_out_vld});
        chk($sformatf("v%0d out_req_addr", idx), out_req_addr, e_addr);
        chk($sformatf("v%0d out_req_opcode", idx), {28'h0, out_req_opcode}, {28'h0, e_op});
        chk($sformatf("v%0d drop_cnt", idx), {16'h0, drop_cnt}, 32'(e_drop));
        chk($sformatf("v%0d issue_cnt", idx), {16'h0, issue_cnt}, 32'(e_issue));
    endtask

    initial begin
        // Basic fill with arbiter stalled, then drain in order.
        push(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 0, 0);
        push(1'b1, 32'h101, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 0, 0);
        push(1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 0, 0);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 0, 1);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 0, 2);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h102, 0, 3);
        // Fill to full; a fifth request is refused, even while the head dequeues.
        push(1'b1, 32'h110, 1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 0, 3);
        push(1'b1, 32'h111, 1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 0, 3);
        push(1'b1, 32'h112, 1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 0, 3);
        push(1'b1, 32'h113, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 0, 3);
        push(1'b1, 32'h114, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 0, 3);
        push(1'b1, 32'h114, 1'b1, 1'b0, 1'b1, 1'b1, 32'h111, 0, 4);
        push(1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h111, 0, 4);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h112, 0, 5);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h113, 0, 6);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h113, 0, 7);
        // Queue hit, then history hit.
        push(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 0, 7);
        push(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1, 7);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1, 8);
        push(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 2, 8);
        // Stream A0..A4 through with simultaneous enqueue/dequeue; A0 ages out.
        push(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 2, 8);
        push(1'b1, 32'h401, 1'b1, 1'b0, 1'b1, 1'b1, 32'h401, 2, 9);
        push(1'b1, 32'h402, 1'b1, 1'b0, 1'b1, 1'b1, 32'h402, 2, 10);
        push(1'b1, 32'h403, 1'b1, 1'b0, 1'b1, 1'b1, 32'h403, 2, 11);
        push(1'b1, 32'h404, 1'b1, 1'b0, 1'b1, 1'b1, 32'h404, 2, 12);
        push(1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h404, 2, 13);
        push(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 2, 13);
        push(1'b1, 32'h404, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 3, 13);
        // Flush with two entries queued, a request and an output handshake in the same cycle.
        push(1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 3, 13);
        push(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 3, 13);
        push(1'b1, 32'h404, 1'b0, 1'b0, 1'b1, 1'b1, 32'h404, 3, 13);
        push(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 32'h404, 3, 13);
        push(1'b1, 32'h401, 1'b0, 1'b0, 1'b1, 1'b1, 32'h404, 3, 13);
        // Request matching the entry being dequeued this cycle is dropped.
        push(1'b1, 32'h404, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 4, 14);
        push(1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 4, 14);
        push(1'b1, 32'h600, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 4, 14);

        // Reset state.
        #2 rst = 1'b1;
        #2;
        check_outputs(-1, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            in_req_vld    = vecs[i].vld;
            in_req_addr   = vecs[i].addr;
            in_req_opcode = op_of(vecs[i].addr);
            out_req_rdy   = vecs[i].rdy;
            flush         = vecs[i].fl;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_in_rdy, vecs[i].e_out_vld, vecs[i].e_addr,
                          op_of(vecs[i].e_addr), vecs[i].e_drop, vecs[i].e_issue);
        end

        // Asynchronous reset mid-stream with three entries queued.
        in_req_vld  = 1'b0;
        out_req_rdy = 1'b0;
        flush       = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_outputs(100, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(101, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);

        // Previously issued address is accepted after reset clears history.
        in_req_vld    = 1'b1;
        in_req_addr   = 32'h404;
        in_req_opcode = op_of(32'h404);
        @(posedge clk);
        #1;
        check_outputs(102, 1'b1, 1'b1, 32'h404, op_of(32'h404), 0, 0);
        in_req_vld = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
